delay_line: RTL and testbench

//  Runtime-programmable multi-bit delay line for sniffer datapath alignment (ULPI data/ctrl vs. strobes).

---
 rtl/delay_line.sv | 124 ++++++++++++
 tb/tb_delay_line.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/delay_line.sv
// Runtime-programmable WIDTH-bit delay line (1..MAX_DELAY enabled steps) built on a circular buffer,
// with stall, flush, on-the-fly reconfiguration and an out_valid flag for real history.
module delay_line #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned MAX_DELAY     = 16,
  parameter int unsigned DEFAULT_DELAY = 2,
  localparam int unsigned AW           = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             cfg_load,
  input  logic [AW-1:0]    delay_sel,
  input  logic [WIDTH-1:0] sig_in,
  output logic [WIDTH-1:0] sig_out,
  output logic             out_valid,
  output logic [AW-1:0]    delay_cur,
  output logic             cfg_err
);

  localparam int unsigned PW    = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam logic [AW-1:0] MAX_D = AW'(MAX_DELAY);
  localparam logic [AW-1:0] DEF_D = AW'(DEFAULT_DELAY);
  localparam logic [AW-1:0] ONE_D = AW'(1);
  localparam logic [PW-1:0] LAST  = PW'(MAX_DELAY - 1);

  logic [WIDTH-1:0] mem [MAX_DELAY];
  logic [PW-1:0]    wr_ptr;
  logic [AW-1:0]    fill;

  logic [AW-1:0]    clamp_sel;
  logic             clamp_hit;
  logic [AW-1:0]    d_eff;
  logic             push;
  logic             update_out;
  logic [AW-1:0]    fill_base;
  logic [AW-1:0]    fill_nxt;
  logic             valid_nxt;
  logic [AW-1:0]    back;
  logic [AW-1:0]    wp_ext;
  logic [AW-1:0]    rd_full;
  logic [PW-1:0]    rd_idx;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] sig_out_nxt;
  logic [PW-1:0]    wr_ptr_nxt;

  // Next-state logic: clamp, fill tracking and read index into the ring
  always_comb begin
    clamp_sel   = delay_sel;
    clamp_hit   = 1'b0;
    d_eff       = delay_cur;
    push        = 1'b0;
    update_out  = 1'b0;
    fill_base   = fill;
    fill_nxt    = fill;
    valid_nxt   = 1'b0;
    back        = '0;
    wp_ext      = '0;
    rd_full     = '0;
    rd_idx      = '0;
    rd_data     = '0;
    sig_out_nxt = '0;
    wr_ptr_nxt  = wr_ptr;

    if (delay_sel == '0) begin
      clamp_sel = ONE_D;
      clamp_hit = 1'b1;
    end else if (delay_sel > MAX_D) begin
      clamp_sel = MAX_D;
      clamp_hit = 1'b1;
    end

    if (cfg_load) d_eff = clamp_sel;

    push       = en && !flush;
    update_out = push || flush || cfg_load;

    if (flush || cfg_load) fill_base = '0;
    fill_nxt = fill_base;
    if (push) fill_nxt = (fill_base >= d_eff) ? d_eff : fill_base + ONE_D;
    valid_nxt = (fill_nxt >= d_eff);

    // Read slot sits D-1 entries behind the slot being written; wrap without underflow
    back   = d_eff - ONE_D;
    wp_ext = AW'(wr_ptr);
    if (wp_ext >= back) rd_full = wp_ext - back;
    else                rd_full = (MAX_D - back) + wp_ext;
    rd_idx = PW'(rd_full);

    // D=1 reads the slot being written this edge, so bypass the array
    rd_data     = (d_eff == ONE_D) ? sig_in : mem[rd_idx];
    sig_out_nxt = valid_nxt ? rd_data : '0;

    if (push) wr_ptr_nxt = (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_out   <= '0;
      out_valid <= 1'b0;
      cfg_err   <= 1'b0;
      delay_cur <= DEF_D;
      fill      <= '0;
      wr_ptr    <= '0;
    end else begin
      cfg_err <= cfg_load && clamp_hit;
      if (cfg_load) delay_cur <= clamp_sel;
      fill   <= fill_nxt;
      wr_ptr <= wr_ptr_nxt;
      if (update_out) begin
        sig_out   <= sig_out_nxt;
        out_valid <= valid_nxt;
      end
    end
  end

  // Storage is never reset; fill gating keeps unwritten entries off the output
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sig_in;
  end

endmodule

// File: tb/tb_delay_line.sv
// Scoreboard bench for delay_line: a history-queue reference model predicts each cycle's outputs,
// and a monitor compares them one cycle later.
module tb_delay_line;

  localparam int unsigned WIDTH         = 8;
  localparam int unsigned MAX_DELAY     = 16;
  localparam int unsigned DEFAULT_DELAY = 2;
  localparam int unsigned AW            = $clog2(MAX_DELAY + 1);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             valid;
    logic [AW-1:0]    dly;
    logic             err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             flush;
  logic             cfg_load;
  logic [AW-1:0]    delay_sel;
  logic [WIDTH-1:0] sig_in;
  logic [WIDTH-1:0] sig_out;
  logic             out_valid;
  logic [AW-1:0]    delay_cur;
  logic             cfg_err;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] hist[$];
  int               model_d;
  int               checks   = 0;
  int               failures = 0;
  exp_t             mon_x;

  delay_line #(
    .WIDTH(WIDTH),
    .MAX_DELAY(MAX_DELAY),
    .DEFAULT_DELAY(DEFAULT_DELAY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .flush(flush),
    .cfg_load(cfg_load),
    .delay_sel(delay_sel),
    .sig_in(sig_in),
    .sig_out(sig_out),
    .out_valid(out_valid),
    .delay_cur(delay_cur),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs and predict the outputs after the following posedge
  task automatic step(input logic e, input logic f, input logic c,
                      input logic [AW-1:0] s, input logic [WIDTH-1:0] d);
    exp_t x;
    int   req;
    @(negedge clk);
    en = e; flush = f; cfg_load = c; delay_sel = s; sig_in = d;
    x = '0;
    if (c) begin
      req = int'(s);
      if (req == 0) begin
        model_d = 1; x.err = 1'b1;
      end else if (req > int'(MAX_DELAY)) begin
        model_d = int'(MAX_DELAY); x.err = 1'b1;
      end else begin
        model_d = req;
      end
      hist.delete();
    end
    if (f) hist.delete();
    else if (e) begin
      hist.push_back(d);
      if (hist.size() > int'(MAX_DELAY)) void'(hist.pop_front());
    end
    x.valid = (hist.size() >= model_d);
    x.data  = x.valid ? hist[hist.size() - model_d] : '0;
    x.dly   = AW'(model_d);
    exp_q.push_back(x);
  endtask

  task automatic model_reset();
    hist.delete();
    model_d = int'(DEFAULT_DELAY);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sig_out"},   32'(sig_out),   32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_delay_cur"}, 32'(delay_cur), 32'(DEFAULT_DELAY));
    check({tag, "_cfg_err"},   32'(cfg_err),   32'd0);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_x = exp_q.pop_front();
      check("sig_out",   32'(sig_out),   32'(mon_x.data));
      check("out_valid", 32'(out_valid), 32'(mon_x.valid));
      check("delay_cur", 32'(delay_cur), 32'(mon_x.dly));
      check("cfg_err",   32'(cfg_err),   32'(mon_x.err));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; cfg_load = 1'b0; delay_sel = '0; sig_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;

    // Default D=2 fill and stream
    for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, 1'b0, '0, WIDTH'(i));

    // Maximum delay with pointer wrap
    step(1'b1, 1'b0, 1'b1, AW'(16), '0);
    for (int i = 1; i <= 31; i++) step(1'b1, 1'b0, 1'b0, '0, WIDTH'(i));

    // D=4 with a three-cycle stall mid-stream
    step(1'b1, 1'b0, 1'b1, AW'(4), 8'h40);
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 1'b0, '0, WIDTH'(8'h40 + i));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, AW'(9), WIDTH'($urandom));
    for (int i = 6; i <= 12; i++) step(1'b1, 1'b0, 1'b0, '0, WIDTH'(8'h40 + i));

    // Clamping: 0 -> 1, 20 -> MAX, and an in-range load while stalled
    step(1'b1, 1'b0, 1'b1, AW'(0), 8'h01);
    step(1'b1, 1'b0, 1'b0, '0, 8'h02);
    step(1'b1, 1'b0, 1'b0, '0, 8'h03);
    step(1'b1, 1'b0, 1'b1, AW'(20), 8'h04);
    step(1'b1, 1'b0, 1'b0, '0, 8'h05);
    step(1'b0, 1'b0, 1'b1, AW'(5), 8'h06);
    step(1'b0, 1'b0, 1'b0, '0, 8'h07);

    // flush+en at D=3 discards 0xAA
    step(1'b1, 1'b0, 1'b1, AW'(3), 8'h10);
    for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 1'b0, '0, WIDTH'(8'h10 + i));
    step(1'b1, 1'b1, 1'b0, '0, 8'hAA);
    for (int i = 4; i <= 9; i++) step(1'b1, 1'b0, 1'b0, '0, WIDTH'(8'h10 + i));
    step(1'b1, 1'b1, 1'b1, AW'(1), 8'hBB);
    step(1'b1, 1'b0, 1'b0, '0, 8'hCC);

    // Asynchronous reset mid-stream at D=5, then refill at the default delay
    step(1'b1, 1'b0, 1'b1, AW'(5), 8'h50);
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b0, '0, WIDTH'(8'h50 + i));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    model_reset();
    @(negedge clk);
    en = 1'b1; sig_in = 8'hEE;
    @(negedge clk);
    check_reset_outputs("rst_hold");
    rst = 1'b0; en = 1'b0;
    for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, 1'b0, '0, WIDTH'(i));

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 8),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 29) == 0),
           AW'($urandom_range(0, 20)),
           WIDTH'($urandom));
    end

    @(posedge clk);
    #2;
    check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
